bht_predictor: RTL

//   Parametrised dynamic branch predictor for the IF unit. Holds a direct-mapped

---
 rtl/bht_predictor.sv | 98 +++++++++
 1 files changed

// File: rtl/bht_predictor.sv
// Direct-mapped table of saturating branch counters for the IF unit.
// Decodes JAL/BRANCH combinationally and is trained by the commit stage.
module bht_predictor #(
    parameter int BHT_ADDR_WIDTH = 8,
    parameter int CNT_WIDTH      = 2,
    parameter int INIT_CNT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] query_pc,
    input  logic [31:0] query_inst,
    output logic        predicted_jump,
    output logic [31:0] predicted_imm,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken
);

    localparam int ENTRIES = 1 << BHT_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(INIT_CNT);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    generate
        if (INIT_CNT < 0 || INIT_CNT >= (1 << CNT_WIDTH)) begin : g_bad_init
            $error("bht_predictor: INIT_CNT does not fit in CNT_WIDTH bits");
        end
    endgenerate

    logic [CNT_WIDTH-1:0]      r_cnt [ENTRIES];
    logic [BHT_ADDR_WIDTH-1:0] w_qidx;
    logic [BHT_ADDR_WIDTH-1:0] w_uidx;
    logic [CNT_WIDTH-1:0]      w_qcnt;
    logic [CNT_WIDTH-1:0]      w_ucnt;
    logic [CNT_WIDTH-1:0]      w_ucnt_next;
    logic [6:0]                w_opcode;
    logic [31:0]               w_j_imm;
    logic [31:0]               w_b_imm;
    logic                      w_unused;

    assign w_qidx   = query_pc[BHT_ADDR_WIDTH+1:2];
    assign w_uidx   = update_pc[BHT_ADDR_WIDTH+1:2];
    assign w_qcnt   = r_cnt[w_qidx];
    assign w_ucnt   = r_cnt[w_uidx];
    assign w_opcode = query_inst[6:0];

    assign w_j_imm = {{12{query_inst[31]}}, query_inst[19:12],
                      query_inst[20], query_inst[30:21], 1'b0};
    assign w_b_imm = {{20{query_inst[31]}}, query_inst[7],
                      query_inst[30:25], query_inst[11:8], 1'b0};

    // PC bits outside the index field never affect the table.
    assign w_unused = ^{query_pc[31:BHT_ADDR_WIDTH+2], query_pc[1:0],
                        update_pc[31:BHT_ADDR_WIDTH+2], update_pc[1:0]};

    // Saturating step of the addressed counter toward the resolved outcome.
    always_comb begin
        w_ucnt_next = w_ucnt;
        if (update_taken) begin
            if (w_ucnt != CNT_MAX) w_ucnt_next = w_ucnt + 1'b1;
        end else begin
            if (w_ucnt != CNT_ZERO) w_ucnt_next = w_ucnt - 1'b1;
        end
    end

    // Counter table: async reset to INIT_CNT, otherwise train one entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
        end else if (rdy && update_valid) begin
            r_cnt[w_uidx] <= w_ucnt_next;
        end
    end

    // Zero-latency decode of the fetched word; JALR falls into default.
    always_comb begin
        predicted_jump = 1'b0;
        predicted_imm  = 32'd0;
        case (w_opcode)
            OP_JAL: begin
                predicted_jump = 1'b1;
                predicted_imm  = w_j_imm;
            end
            OP_BRANCH: begin
                predicted_jump = w_qcnt[CNT_WIDTH-1];
                predicted_imm  = w_b_imm;
            end
            default: begin
                predicted_jump = 1'b0;
                predicted_imm  = 32'd0;
            end
        endcase
    end

endmodule
